// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with write-back bypass, 8-entry scoreboard and
// RAW/WAW hazard stall between decode and execute.
module operand_fetch #(
    parameter int DW = 32,
    parameter int AW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_op,
    input  logic [AW-1:0] in_ra1,
    input  logic [AW-1:0] in_ra2,
    input  logic [AW-1:0] in_wa,
    input  logic          in_we,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    output logic [AW-1:0] rf_ra1,
    output logic [AW-1:0] rf_ra2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wa,
    input  logic [DW-1:0] wb_wd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    out_op,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [AW-1:0] out_wa,
    output logic          out_we,
    output logic [CW-1:0] stall_cnt
);
    localparam int NR = 1 << AW;

    logic [NR-1:0] pend_q, pend_d, clr, set, eff;
    logic [CW-1:0] stall_q, stall_d;
    logic          valid_q, we_q, hz, fire;
    logic [5:0]    op_q;
    logic [DW-1:0] a_q, b_q, op_a, op_b;
    logic [AW-1:0] wa_q;

    assign rf_ra1 = in_ra1;
    assign rf_ra2 = in_ra2;

    assign op_a = (wb_we && wb_wa == in_ra1) ? wb_wd : rf_rd1;
    assign op_b = in_use_imm ? in_imm : ((wb_we && wb_wa == in_ra2) ? wb_wd : rf_rd2);

    // a same-cycle write-back resolves the hazard it clears
    assign clr = wb_we ? NR'(1) << wb_wa : '0;
    assign eff = pend_q & ~clr;
    assign hz  = in_valid && (eff[in_ra1] || (!in_use_imm && eff[in_ra2]) || (in_we && eff[in_wa]));

    assign in_ready = !hz && (!valid_q || out_ready);
    assign fire     = in_valid && in_ready;

    assign set     = (fire && in_we) ? NR'(1) << in_wa : '0;
    assign pend_d  = eff | set;
    assign stall_d = (hz && stall_q != '1) ? stall_q + CW'(1) : stall_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wa_q    <= '0;
            we_q    <= 1'b0;
            pend_q  <= '0;
            stall_q <= '0;
        end else begin
            pend_q  <= pend_d;
            stall_q <= stall_d;
            if (fire) begin
                valid_q <= 1'b1;
                op_q    <= in_op;
                a_q     <= op_a;
                b_q     <= op_b;
                wa_q    <= in_wa;
                we_q    <= in_we;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_wa    = wa_q;
    assign out_we    = we_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector table plus hand sequences for async reset and
// stall-counter saturation (counter narrowed to 4 bits so it saturates quickly).
module tb_operand_fetch;
    localparam int DW = 32, AW = 3, CW = 4;

    logic          clk = 1'b0, n_rst = 1'b0;
    logic          in_valid = 0, in_ready, in_we = 0, in_use_imm = 0;
    logic [5:0]    in_op = 0, out_op;
    logic [AW-1:0] in_ra1 = 0, in_ra2 = 0, in_wa = 0, rf_ra1, rf_ra2, wb_wa = 0, out_wa;
    logic [DW-1:0] in_imm = 0, rf_rd1 = 0, rf_rd2 = 0, wb_wd = 0, out_a, out_b;
    logic          wb_we = 0, out_valid, out_ready = 1, out_we;
    logic [CW-1:0] stall_cnt;

    int errors = 0, checks = 0;

    operand_fetch #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_ra1(in_ra1), .in_ra2(in_ra2), .in_wa(in_wa), .in_we(in_we), .in_use_imm(in_use_imm),
        .in_imm(in_imm), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_wa(out_wa), .out_we(out_we),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [5:0]    op;
        logic [AW-1:0] ra1, ra2, wa;
        logic          we, ui;
        logic [DW-1:0] imm, rd1, rd2;
        logic          wwe;
        logic [AW-1:0] wwa;
        logic [DW-1:0] wwd;
        logic          ordy;
        logic          e_rdy, e_ov;
        logic [5:0]    e_op;
        logic [DW-1:0] e_a, e_b;
        logic [AW-1:0] e_wa;
        logic          e_we;
        logic [CW-1:0] e_sc;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        in_valid = t.v; in_op = t.op; in_ra1 = t.ra1; in_ra2 = t.ra2; in_wa = t.wa;
        in_we = t.we; in_use_imm = t.ui; in_imm = t.imm; rf_rd1 = t.rd1; rf_rd2 = t.rd2;
        wb_we = t.wwe; wb_wa = t.wwa; wb_wd = t.wwd; out_ready = t.ordy;
    endtask

    initial begin
        // issue, RAW stall and bypass-resolve
        tv.push_back('{1,5,1,2,3,1,0,0,32'h11111111,32'h22222222,0,0,0,1, 1,1,5,32'h11111111,32'h22222222,3,1,0});
        tv.push_back('{1,1,3,0,5,1,0,0,0,0,0,0,0,1, 0,0,5,32'h11111111,32'h22222222,3,1,1});
        tv.push_back('{1,1,3,0,5,1,0,0,0,0,0,0,0,1, 0,0,5,32'h11111111,32'h22222222,3,1,2});
        tv.push_back('{1,1,3,0,5,1,0,0,0,0,1,3,32'haaaaaaaa,1, 1,1,1,32'haaaaaaaa,0,5,1,2});
        tv.push_back('{1,2,3,3,0,0,0,0,32'h33,32'h44,0,0,0,1, 1,1,2,32'h33,32'h44,0,0,2});
        // immediate path ignores pending ra2; same with register B stalls; WAW stalls
        tv.push_back('{1,3,0,0,4,1,0,0,1,2,0,0,0,1, 1,1,3,1,2,4,1,2});
        tv.push_back('{1,4,1,4,7,0,1,32'h12345678,32'h55,32'h66,0,0,0,1, 1,1,4,32'h55,32'h12345678,7,0,2});
        tv.push_back('{1,4,1,4,7,0,0,0,32'h55,32'h66,0,0,0,1, 0,0,4,32'h55,32'h12345678,7,0,3});
        tv.push_back('{1,5,0,0,5,1,0,0,0,0,0,0,0,1, 0,0,4,32'h55,32'h12345678,7,0,4});
        tv.push_back('{0,0,0,0,0,0,0,0,0,0,1,4,0,1, 1,0,4,32'h55,32'h12345678,7,0,4});
        // back-pressure holds outputs without counting stalls
        tv.push_back('{1,6,1,2,1,0,0,0,32'h77,32'h88,0,0,0,1, 1,1,6,32'h77,32'h88,1,0,4});
        tv.push_back('{1,7,2,2,2,0,0,0,32'h99,32'haa,0,0,0,0, 0,1,6,32'h77,32'h88,1,0,4});
        tv.push_back('{1,7,2,2,2,0,0,0,32'h99,32'haa,0,0,0,0, 0,1,6,32'h77,32'h88,1,0,4});
        tv.push_back('{1,7,2,2,2,0,0,0,32'h99,32'haa,0,0,0,1, 1,1,7,32'h99,32'haa,2,0,4});
        // set/clear collision keeps the bit set
        tv.push_back('{1,8,0,0,6,1,0,0,0,0,0,0,0,1, 1,1,8,0,0,6,1,4});
        tv.push_back('{1,9,1,2,6,1,0,0,32'hc,32'hd,1,6,32'hbbbbbbbb,1, 1,1,9,32'hc,32'hd,6,1,4});
        tv.push_back('{1,10,6,0,0,0,0,0,0,0,0,0,0,1, 0,0,9,32'hc,32'hd,6,1,5});
        tv.push_back('{1,11,0,6,0,0,0,0,1,2,1,6,32'hbbbbbbbb,1, 1,1,11,1,32'hbbbbbbbb,0,0,5});
        tv.push_back('{1,12,5,0,0,0,0,0,0,0,0,0,0,1, 0,0,11,1,32'hbbbbbbbb,0,0,6});

        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_a", out_a, 0);
        chk("rst out_op", 32'(out_op), 0);
        chk("rst stall_cnt", 32'(stall_cnt), 0);
        n_rst = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d rf_ra1", i), 32'(rf_ra1), 32'(tv[i].ra1));
            chk($sformatf("v%0d rf_ra2", i), 32'(rf_ra2), 32'(tv[i].ra2));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
            chk($sformatf("v%0d out_op", i), 32'(out_op), 32'(tv[i].e_op));
            chk($sformatf("v%0d out_a", i), out_a, tv[i].e_a);
            chk($sformatf("v%0d out_b", i), out_b, tv[i].e_b);
            chk($sformatf("v%0d out_wa", i), 32'(out_wa), 32'(tv[i].e_wa));
            chk($sformatf("v%0d out_we", i), 32'(out_we), 32'(tv[i].e_we));
            chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(tv[i].e_sc));
        end

        // async reset while stalled on pending r5, between clock edges
        #3 n_rst = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 0);
        chk("arst stall_cnt", 32'(stall_cnt), 0);
        chk("arst out_op", 32'(out_op), 0);
        chk("arst pending cleared", 32'(in_ready), 1);
        in_valid = 1'b0;
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst idle out_valid", 32'(out_valid), 0);

        // saturation of the stall counter
        in_valid = 1; in_op = 1; in_ra1 = 0; in_ra2 = 0; in_wa = 2; in_we = 1; in_use_imm = 0;
        wb_we = 0; out_ready = 1;
        @(posedge clk);
        #1;
        in_ra1 = 2; in_wa = 0; in_we = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("sat stall_cnt", 32'(stall_cnt), 15);
        chk("sat in_ready", 32'(in_ready), 0);
        wb_we = 1; wb_wa = 2; wb_wd = 32'hdeadbeef;
        #1;
        chk("sat wb resolve in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("sat bypass out_a", out_a, 32'hdeadbeef);
        chk("sat hold stall_cnt", 32'(stall_cnt), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage directly downstream of register_file, between decode and execute.
- Drives the register file read addresses from the decoded instruction and captures rd1/rd2 into an output pipeline register.
- Bypasses the same-cycle write-back value. Tracks in-flight destination registers in an 8-entry scoreboard and stalls on RAW/WAW hazards.
- Uses valid/ready handshakes on both sides.

Parameters:
- DW, 32, data width; matches the register file.
- AW, 3, register address width; the scoreboard depth is 2**AW = 8.
- CW, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  6  opcode; passed through unchanged.
- in_ra1, in_ra2  in  AW  source register addresses.
- in_wa  in  AW  destination register address.
- in_we  in  1  instruction writes in_wa.
- in_use_imm  in  1  operand B is in_imm; in_ra2 is ignored for hazards.
- in_imm  in  DW  immediate.
- rf_ra1, rf_ra2  out  AW  register file read addresses.
- rf_rd1, rf_rd2  in  DW  register file read data; combinational in rf_ra*.
- wb_we, wb_wa, wb_wd  in  1/AW/DW  write-back port; the same signals drive the register_file write port.
- out_valid  out  1  operands valid toward execute.
- out_ready  in  1  execute accepts.
- out_op  out  6  registered opcode.
- out_a, out_b  out  DW  registered operands.
- out_wa  out  AW  registered destination.
- out_we  out  1  registered write enable.
- stall_cnt  out  CW  hazard-stall cycles, saturating.

Behaviour:
- Reset (asynchronous, n_rst=0):
  - out_valid=0; out_op, out_a, out_b, out_wa, out_we = 0.
  - scoreboard pending[7:0]=0; stall_cnt=0.
  - Reset mid-operation drops the held instruction and all pending bits. Upstream must also be reset.
- Read addressing: rf_ra1=in_ra1 and rf_ra2=in_ra2, combinational and unconditional.
- Bypass:
  - opA = (wb_we && wb_wa==in_ra1) ? wb_wd : rf_rd1.
  - opB = in_use_imm ? in_imm : ((wb_we && wb_wa==in_ra2) ? wb_wd : rf_rd2).
- clr = wb_we ? onehot(wb_wa) : 0. eff = pending & ~clr, i.e. a write-back in the same cycle resolves the hazard.
- Hazard (combinational):
  - hz = in_valid && (eff[in_ra1] || (!in_use_imm && eff[in_ra2]) || (in_we && eff[in_wa])).
- Handshake:
  - in_ready = !hz && (!out_valid || out_ready).
  - fire = in_valid && in_ready.
  - out_* hold their value while out_valid && !out_ready.
- Output register, each clock:
  - If fire: out_valid<=1; out_op<=in_op; out_a<=opA; out_b<=opB; out_wa<=in_wa; out_we<=in_we.
  - Else if out_ready: out_valid<=0.
  - Latency: 1 cycle from acceptance to out_valid.
- Scoreboard:
  - set = (fire && in_we) ? onehot(in_wa) : 0.
  - pending <= (pending & ~clr) | set. Set wins when clr and set hit the same bit.
  - A write-back to a non-pending register is legal and leaves pending unchanged.
- stall_cnt: increments by 1 each cycle hz=1, saturating at 2**CW-1. A back-pressure stall (out_valid && !out_ready with hz=0) does not count.
- Values are passed through as raw DW-bit vectors; there is no arithmetic on data.

Test Plan:
- Reset + basic issue:
  - Stimulus: pulse n_rst low; then in_valid=1, op=5, ra1=1, ra2=2, wa=3, we=1; rf_rd1=32'h11111111, rf_rd2=32'h22222222; out_ready=1.
  - Response: next cycle out_valid=1, out_a=32'h11111111, out_b=32'h22222222, out_wa=3, pending[3]=1.
- RAW stall:
  - Stimulus: with pending[3]=1, present ra1=3.
  - Response: in_ready=0 and stall_cnt increments each cycle. In the cycle wb_we=1, wb_wa=3, wb_wd=32'haaaaaaaa: in_ready=1, out_a=32'haaaaaaaa next cycle, pending[3]=0.
- Immediate path:
  - Stimulus: pending[4]=1, in_use_imm=1, ra2=4, in_imm=32'h12345678, ra1 free.
  - Response: no stall; out_b=32'h12345678.
- Back-pressure:
  - Stimulus: out_ready=0 while out_valid=1, second instruction valid with no hazard.
  - Response: in_ready=0; out_* unchanged; stall_cnt unchanged. Raising out_ready accepts the second instruction the same cycle.
- Set/clear collision:
  - Stimulus: pending[6]=1; wb clears 6 while an instruction with we=1, wa=6 fires.
  - Response: pending[6]=1 after the edge.
- Async reset mid-stall:
  - Stimulus: assert n_rst=0 between clock edges while stalled.
  - Response: out_valid=0, pending=0, stall_cnt=0 immediately, without a clock edge.
